// File: rtl/niosii_system_sysid_pkg.sv
// Shared definitions for the sysid checker: FSM encoding, sysid word addresses
// and the timeout counter width rule.
package niosii_system_sysid_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRdId,
    StLatId,
    StRdTs,
    StLatTs,
    StFin
  } sysid_state_e;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  // Wide enough to hold max_cycles, never narrower than 8 bits.
  function automatic int unsigned tmo_width(int unsigned max_cycles);
    int unsigned w;
    w = $clog2(max_cycles + 1);
    return (w < 8) ? 8 : w;
  endfunction

endpackage

// File: rtl/niosii_system_sysid_lat_cnt.sv
// Loadable down counter that saturates at zero; expired flags the zero state.
// Shared by the stall-timeout and read-latency timers.
module niosii_system_sysid_lat_cnt #(
  parameter int unsigned Width = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             dec,
  output logic             expired
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/niosii_system_sysid_checker.sv
// Avalon-MM master that reads the sysid ID and timestamp words, compares them
// with the expected build and latches a sticky pass / timeout status.
module niosii_system_sysid_checker
  import niosii_system_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'h5514_3DE8,
  parameter bit          CHECK_TS       = 1'b1,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        match,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam int unsigned TmoWidth   = tmo_width(TIMEOUT_CYCLES);
  localparam int unsigned LatWidth   = 2;
  // Counters expire at zero, so load one less than the number of cycles wanted.
  localparam int unsigned TmoLoadInt = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam int unsigned LatLoadInt = (READ_LATENCY > 0) ? READ_LATENCY - 1 : 0;
  localparam logic [TmoWidth-1:0] TmoLoad = TmoWidth'(TmoLoadInt);
  localparam logic [LatWidth-1:0] LatLoad = LatWidth'(LatLoadInt);

  sysid_state_e state_q, state_d;
  logic [31:0]  id_q, id_d;
  logic [31:0]  ts_q, ts_d;
  logic         match_q, match_d;
  logic         tmo_err_q, tmo_err_d;
  logic         auto_q, auto_d;

  logic tmo_load, tmo_dec, tmo_expired;
  logic lat_load, lat_dec, lat_expired;

  niosii_system_sysid_lat_cnt #(
    .Width (TmoWidth)
  ) u_tmo_cnt (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (tmo_load),
    .load_val (TmoLoad),
    .dec      (tmo_dec),
    .expired  (tmo_expired)
  );

  niosii_system_sysid_lat_cnt #(
    .Width (LatWidth)
  ) u_lat_cnt (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (lat_load),
    .load_val (LatLoad),
    .dec      (lat_dec),
    .expired  (lat_expired)
  );

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    ts_d      = ts_q;
    match_d   = match_q;
    tmo_err_d = tmo_err_q;
    auto_d    = auto_q;
    tmo_load  = 1'b0;
    tmo_dec   = 1'b0;
    lat_load  = 1'b0;
    lat_dec   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start || auto_q) begin
          state_d   = StRdId;
          auto_d    = 1'b0;
          match_d   = 1'b0;
          tmo_err_d = 1'b0;
          tmo_load  = 1'b1;
        end
      end
      StRdId: begin
        if (!avm_waitrequest) begin
          if (READ_LATENCY == 0) begin
            id_d     = avm_readdata;
            state_d  = StRdTs;
            tmo_load = 1'b1;
          end else begin
            lat_load = 1'b1;
            state_d  = StLatId;
          end
        end else if (tmo_expired) begin
          state_d   = StFin;
          tmo_err_d = 1'b1;
          match_d   = 1'b0;
        end else begin
          tmo_dec = 1'b1;
        end
      end
      StLatId: begin
        if (lat_expired) begin
          id_d     = avm_readdata;
          state_d  = StRdTs;
          tmo_load = 1'b1;
        end else begin
          lat_dec = 1'b1;
        end
      end
      StRdTs: begin
        if (!avm_waitrequest) begin
          if (READ_LATENCY == 0) begin
            ts_d    = avm_readdata;
            state_d = StFin;
            match_d = (id_q == EXPECTED_ID) && (!CHECK_TS || (ts_d == EXPECTED_TS));
          end else begin
            lat_load = 1'b1;
            state_d  = StLatTs;
          end
        end else if (tmo_expired) begin
          state_d   = StFin;
          tmo_err_d = 1'b1;
          match_d   = 1'b0;
        end else begin
          tmo_dec = 1'b1;
        end
      end
      StLatTs: begin
        if (lat_expired) begin
          ts_d    = avm_readdata;
          state_d = StFin;
          // Status is latched on FIN entry so it is valid alongside done.
          match_d = (id_q == EXPECTED_ID) && (!CHECK_TS || (ts_d == EXPECTED_TS));
        end else begin
          lat_dec = 1'b1;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      id_q      <= '0;
      ts_q      <= '0;
      match_q   <= 1'b0;
      tmo_err_q <= 1'b0;
      auto_q    <= AUTO_START;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      ts_q      <= ts_d;
      match_q   <= match_d;
      tmo_err_q <= tmo_err_d;
      auto_q    <= auto_d;
    end
  end

  // Bus strobes decode the state register only, so waitrequest never reaches them.
  assign avm_read    = (state_q == StRdId) || (state_q == StRdTs);
  assign avm_address = ((state_q == StRdTs) || (state_q == StLatTs)) ? SYSID_ADDR_TS
                                                                      : SYSID_ADDR_ID;
  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StFin);
  assign match       = match_q;
  assign timeout_err = tmo_err_q;
  assign id_value    = id_q;
  assign ts_value    = ts_q;

endmodule

// File: tb/tb_niosii_system_sysid_checker.sv
// Directed bench: a sysid slave model with programmable stalls drives two checkers
// that differ only in CHECK_TS.
module tb_niosii_system_sysid_checker;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        avm_address, avm_read, avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        busy, done, match, timeout_err;
  logic [31:0] id_value, ts_value;

  logic        b_address, b_read, b_busy, b_done, b_match, b_timeout_err;
  logic [31:0] b_id_value, b_ts_value;

  logic [31:0] id_word = 32'h0000_0000;
  logic [31:0] ts_word = 32'h5514_3DE8;
  int          stall_cfg = 0;
  bit          stuck = 1'b0;
  int          stall_cnt = 0;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  niosii_system_sysid_checker #(
    .EXPECTED_ID    (32'h0000_0000),
    .EXPECTED_TS    (32'h5514_3DE8),
    .CHECK_TS       (1'b1),
    .READ_LATENCY   (1),
    .TIMEOUT_CYCLES (10),
    .AUTO_START     (1'b1)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .start           (start),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_waitrequest (avm_waitrequest),
    .avm_readdata    (avm_readdata),
    .busy            (busy),
    .done            (done),
    .match           (match),
    .timeout_err     (timeout_err),
    .id_value        (id_value),
    .ts_value        (ts_value)
  );

  // Runs in lockstep with dut, so it can share the slave model.
  niosii_system_sysid_checker #(
    .EXPECTED_ID    (32'h0000_0000),
    .EXPECTED_TS    (32'h5514_3DE8),
    .CHECK_TS       (1'b0),
    .READ_LATENCY   (1),
    .TIMEOUT_CYCLES (10),
    .AUTO_START     (1'b1)
  ) dut_nots (
    .clock           (clock),
    .reset_n         (reset_n),
    .start           (start),
    .avm_address     (b_address),
    .avm_read        (b_read),
    .avm_waitrequest (avm_waitrequest),
    .avm_readdata    (avm_readdata),
    .busy            (b_busy),
    .done            (b_done),
    .match           (b_match),
    .timeout_err     (b_timeout_err),
    .id_value        (b_id_value),
    .ts_value        (b_ts_value)
  );

  assign avm_waitrequest = avm_read && (stuck || (stall_cnt < stall_cfg));

  always @(posedge clock) begin
    if (avm_read && avm_waitrequest) stall_cnt <= stall_cnt + 1;
    else stall_cnt <= 0;
    if (avm_read && !avm_waitrequest) avm_readdata <= avm_address ? ts_word : id_word;
    else avm_readdata <= 32'hDEAD_BEEF;
  end

  task automatic start_pulse;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic run_until_done(input int max_cycles, output int idx);
    idx = -1;
    for (int i = 0; i < max_cycles; i++) begin
      if (done) begin
        idx = i;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clock);
    checks++; if (avm_read !== 1'b0) begin errors++; $display("FAIL reset_read got %b want 0", avm_read); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (match !== 1'b0) begin errors++; $display("FAIL reset_match got %b want 0", match); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_tmo got %b want 0", timeout_err); end
    checks++; if (ts_value !== 32'h0) begin errors++; $display("FAIL reset_ts got %h want 0", ts_value); end
  endtask

  task automatic test_auto_start;
    int done_at;
    @(negedge clock);
    reset_n = 1'b1;
    done_at = -1;
    for (int i = 1; i <= 20 && done_at < 0; i++) begin
      @(negedge clock);
      if (i == 1) begin
        checks++; if ({avm_read, avm_address} !== 2'b10) begin errors++; $display("FAIL auto_rd_id got %b want 10", {avm_read, avm_address}); end
      end
      if (i == 3) begin
        checks++; if ({avm_read, avm_address} !== 2'b11) begin errors++; $display("FAIL auto_rd_ts got %b want 11", {avm_read, avm_address}); end
      end
      if (done) done_at = i;
    end
    checks++; if (done_at !== 5) begin errors++; $display("FAIL auto_done_cycle got %0d want 5", done_at); end
    checks++; if (match !== 1'b1) begin errors++; $display("FAIL auto_match got %b want 1", match); end
    checks++; if (ts_value !== 32'h5514_3DE8) begin errors++; $display("FAIL auto_ts got %h want 55143de8", ts_value); end
    checks++; if (id_value !== 32'h0) begin errors++; $display("FAIL auto_id got %h want 0", id_value); end
    @(negedge clock);
    checks++; if ({busy, done, match} !== 3'b001) begin errors++; $display("FAIL auto_after got %b want 001", {busy, done, match}); end
  endtask

  task automatic test_ts_mismatch;
    int idx;
    ts_word = 32'h1234_5678;
    start_pulse();
    run_until_done(40, idx);
    checks++; if (idx !== 4) begin errors++; $display("FAIL tsmm_done_cycle got %0d want 4", idx); end
    checks++; if (match !== 1'b0) begin errors++; $display("FAIL tsmm_match got %b want 0", match); end
    checks++; if (b_match !== 1'b1) begin errors++; $display("FAIL tsmm_nocheck_match got %b want 1", b_match); end
    checks++; if (ts_value !== 32'h1234_5678) begin errors++; $display("FAIL tsmm_ts got %h want 12345678", ts_value); end
    ts_word = 32'h5514_3DE8;
    @(negedge clock);
  endtask

  task automatic test_stall;
    int rd0, rd1, done_at;
    bit addr_bad;
    rd0 = 0; rd1 = 0; done_at = -1; addr_bad = 1'b0;
    stall_cfg = 3;
    start_pulse();
    for (int i = 0; i < 40 && done_at < 0; i++) begin
      if (avm_read && !avm_address) rd0++;
      if (avm_read && avm_address) rd1++;
      if (avm_read && (avm_address !== ((rd1 > 0) ? 1'b1 : 1'b0))) addr_bad = 1'b1;
      if (done) done_at = i;
      else @(negedge clock);
    end
    stall_cfg = 0;
    checks++; if (rd0 !== 4) begin errors++; $display("FAIL stall_rd_id_cycles got %0d want 4", rd0); end
    checks++; if (rd1 !== 4) begin errors++; $display("FAIL stall_rd_ts_cycles got %0d want 4", rd1); end
    checks++; if (addr_bad !== 1'b0) begin errors++; $display("FAIL stall_addr_stable got %b want 0", addr_bad); end
    checks++; if (done_at !== 10) begin errors++; $display("FAIL stall_done_cycle got %0d want 10", done_at); end
    checks++; if ({match, timeout_err} !== 2'b10) begin errors++; $display("FAIL stall_status got %b want 10", {match, timeout_err}); end
    @(negedge clock);
  endtask

  task automatic test_timeout;
    int idx;
    stuck = 1'b1;
    start_pulse();
    run_until_done(40, idx);
    checks++; if (idx !== 10) begin errors++; $display("FAIL tmo_done_cycle got %0d want 10", idx); end
    checks++; if ({timeout_err, match, avm_read} !== 3'b100) begin errors++; $display("FAIL tmo_status got %b want 100", {timeout_err, match, avm_read}); end
    @(negedge clock);
    stuck = 1'b0;
    checks++; if ({busy, avm_read, timeout_err} !== 3'b001) begin errors++; $display("FAIL tmo_after got %b want 001", {busy, avm_read, timeout_err}); end
  endtask

  task automatic test_back_to_back;
    int ndone, idx;
    ndone = 0;
    start_pulse();
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL b2b_tmo_clear got %b want 0", timeout_err); end
    for (int i = 0; i < 25; i++) begin
      if (i == 2) start = 1'b1;
      if (i == 3) start = 1'b0;
      if (done) ndone++;
      @(negedge clock);
    end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL b2b_done_count got %0d want 1", ndone); end
    checks++; if ({busy, match} !== 2'b01) begin errors++; $display("FAIL b2b_status got %b want 01", {busy, match}); end
    start_pulse();
    checks++; if ({match, timeout_err, busy} !== 3'b001) begin errors++; $display("FAIL b2b_flag_clear got %b want 001", {match, timeout_err, busy}); end
    run_until_done(40, idx);
    checks++; if (idx !== 4) begin errors++; $display("FAIL b2b_restart_cycle got %0d want 4", idx); end
    checks++; if (match !== 1'b1) begin errors++; $display("FAIL b2b_restart_match got %b want 1", match); end
    @(negedge clock);
  endtask

  task automatic test_reset_mid_check;
    int done_at;
    start_pulse();
    repeat (3) @(negedge clock);
    checks++; if ({busy, avm_read, avm_address} !== 3'b101) begin errors++; $display("FAIL mid_lat_ts got %b want 101", {busy, avm_read, avm_address}); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({busy, done, match, avm_read} !== 4'b0000) begin errors++; $display("FAIL mid_async_flags got %b want 0000", {busy, done, match, avm_read}); end
    checks++; if ({id_value, ts_value} !== 64'h0) begin errors++; $display("FAIL mid_async_values got %h want 0", {id_value, ts_value}); end
    @(negedge clock);
    reset_n = 1'b1;
    done_at = -1;
    for (int i = 1; i <= 20 && done_at < 0; i++) begin
      @(negedge clock);
      if (done) done_at = i;
    end
    checks++; if (done_at !== 5) begin errors++; $display("FAIL mid_rerun_cycle got %0d want 5", done_at); end
    checks++; if ({match, ts_value} !== {1'b1, 32'h5514_3DE8}) begin errors++; $display("FAIL mid_rerun_result got %b %h want 1 55143de8", match, ts_value); end
  endtask

  initial begin
    test_reset();
    test_auto_start();
    test_ts_mismatch();
    test_stall();
    test_timeout();
    test_back_to_back();
    test_reset_mid_check();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1);
  end

endmodule
